// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fixed-priority next-PC select with RUN/HALT FSM.
// Optional return stack built only when PC_SEQ_RETURN_STACK_EN is defined.
module pc_sequencer #(
    parameter int                 WIDTH        = 8,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int                 STACK_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             halted,
    output logic             stack_err
);

    typedef enum logic {S_RUN, S_HALT} state_t;

    localparam logic [WIDTH-1:0] ONE = 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + ONE;

`ifdef PC_SEQ_RETURN_STACK_EN
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(STACK_DEPTH);
    localparam logic [AW-1:0] ONE_A   = 1;

    logic [WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_stack_err;
    logic             w_push;
    logic             w_pop;
    logic             w_err_set;
    logic [AW-1:0]    w_top_idx;

    assign w_top_idx = r_count[AW-1:0] - ONE_A;
`endif

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
`ifdef PC_SEQ_RETURN_STACK_EN
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_err_set    = 1'b0;
`endif
        case (r_state)
            S_RUN: begin
                if (halt) begin
                    w_state_next = S_HALT;
                end else if (stall) begin
                    w_pc_next = r_pc;
                end else if (ret) begin
`ifdef PC_SEQ_RETURN_STACK_EN
                    if (r_count != '0) begin
                        w_pop     = 1'b1;
                        w_pc_next = r_stack[w_top_idx];
                    end else begin
                        w_err_set = 1'b1;
                        w_pc_next = w_pc_inc;
                    end
`else
                    w_pc_next = w_pc_inc;
`endif
                end else if (call) begin
`ifdef PC_SEQ_RETURN_STACK_EN
                    if (r_count == DEPTH_C) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
`endif
                    w_pc_next = jump_target;
                end else if (jump) begin
                    w_pc_next = jump_target;
                end else if (branch_taken) begin
                    w_pc_next = r_pc + branch_offset;
                end else begin
                    w_pc_next = w_pc_inc;
                end
            end
            S_HALT: begin
                if (resume && !halt) begin
                    w_state_next = S_RUN;
                end
            end
            default: w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
            r_pc    <= RESET_VECTOR;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

`ifdef PC_SEQ_RETURN_STACK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_stack_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_err_set) begin
                r_stack_err <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read below r_count.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_stack[r_count[AW-1:0]] <= w_pc_inc;
        end
    end

    assign stack_err = r_stack_err;
`else
    assign stack_err = 1'b0;
`endif

    assign pc      = r_pc;
    assign pc_next = w_pc_next;
    assign halted  = (r_state == S_HALT);

endmodule
